// File: rtl/conv_pkg.sv
// Shared types and constants for the padded conv-layer feeder.
// Optional build macro used by this slice: CONV_PAD_FEED_PERF_EN (see conv_pad_feeder).
package conv_pkg;

  localparam int BEAT_W      = 64;
  localparam int CH_PER_BEAT = 8;
  localparam int CH_SHIFT    = $clog2(CH_PER_BEAT);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } feed_state_t;

  // Latched layer geometry: channels, unpadded width/height, beats per pixel.
  typedef struct packed {
    logic [31:0] c;
    logic [31:0] w;
    logic [31:0] h;
    logic [31:0] d;
  } cfg_t;

  // A geometry the window generator cannot take: empty, misaligned or oversized.
  function automatic logic cfg_is_bad(input logic [31:0] c,
                                      input logic [31:0] w,
                                      input logic [31:0] h,
                                      input logic [31:0] max_dim,
                                      input logic [31:0] max_ch);
    return (c == 32'd0) || ((c & 32'(CH_PER_BEAT - 1)) != 32'd0) || (c > max_ch) ||
           (w == 32'd0) || (h == 32'd0) || (w > max_dim) || (h > max_dim);
  endfunction

endpackage

// File: rtl/conv_pad_feeder_pos_counter.sv
// Nested raster position counter: beat (innermost), col, row (outermost).
// Limits are inclusive maxima; last flags the final beat of the frame.
module pos_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] beat_max,
  input  logic [31:0] col_max,
  input  logic [31:0] row_max,
  output logic [31:0] beat,
  output logic [31:0] col,
  output logic [31:0] row,
  output logic        last
);

  logic beat_end;
  logic col_end;
  logic row_end;

  assign beat_end = (beat == beat_max);
  assign col_end  = (col == col_max);
  assign row_end  = (row == row_max);
  assign last     = beat_end && col_end && row_end;

  // Advance one beat per enable, carrying into col then row; clear restarts the frame.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      beat <= 32'd0;
      col  <= 32'd0;
      row  <= 32'd0;
    end else if (en) begin
      if (!beat_end) begin
        beat <= beat + 32'd1;
      end else begin
        beat <= 32'd0;
        if (!col_end) begin
          col <= col + 32'd1;
        end else begin
          col <= 32'd0;
          row <= row_end ? 32'd0 : row + 32'd1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_pad_feeder.sv
// Sequencer that wraps an unpadded HxW feature map with a one-pixel zero
// border and streams it into the 3x3 window generator.
// Build macro: CONV_PAD_FEED_PERF_EN adds perf_stall / perf_pad counters.
module conv_pad_feeder
  import conv_pkg::*;
#(
  parameter int MAX_DIM = 1024,
  parameter int MAX_CH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       cfg_in_channels,
  input  logic [15:0]       cfg_img_width,
  input  logic [15:0]       cfg_img_height,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [BEAT_W-1:0] s_data,
  input  logic              win_ready,
  output logic              win_valid,
  output logic [BEAT_W-1:0] win_pixel,
  output logic [15:0]       win_channels,
  output logic [15:0]       win_width
`ifdef CONV_PAD_FEED_PERF_EN
  ,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_pad
`endif
);

  feed_state_t state;
  feed_state_t state_nxt;
  cfg_t        cfg_q;

  logic [31:0] beat;
  logic [31:0] col;
  logic [31:0] row;
  logic        last;
  logic [31:0] beat_max;
  logic [31:0] col_max;
  logic [31:0] row_max;
  logic        accept;
  logic        bad;
  logic        pad;
  logic        fire;

  assign accept   = (state == IDLE) && start;
  assign bad      = cfg_is_bad(cfg_q.c, cfg_q.w, cfg_q.h, 32'(MAX_DIM), 32'(MAX_CH));
  assign beat_max = cfg_q.d - 32'd1;
  assign col_max  = cfg_q.w + 32'd1;
  assign row_max  = cfg_q.h + 32'd1;

  assign pad     = (row == 32'd0) || (row == row_max) || (col == 32'd0) || (col == col_max);
  assign s_ready = (state == STREAM) && !pad && win_ready;
  assign fire    = (state == STREAM) && win_ready && (pad || s_valid);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  pos_counter u_pos (
    .clk      (clk),
    .rst      (rst),
    .en       (fire),
    .clr      (state != STREAM),
    .beat_max (beat_max),
    .col_max  (col_max),
    .row_max  (row_max),
    .beat     (beat),
    .col      (col),
    .row      (row),
    .last     (last)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: load/check config, stream the padded frame, pulse done.
  // NOTE: state_nxt gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = bad ? DONE : STREAM;
      STREAM:  if (fire && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch geometry on start, derive beats-per-pixel in LOAD, flag bad configs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q        <= '0;
      win_channels <= 16'd0;
      win_width    <= 16'd0;
      cfg_err      <= 1'b0;
    end else if (accept) begin
      cfg_q.c      <= {16'd0, cfg_in_channels};
      cfg_q.w      <= {16'd0, cfg_img_width};
      cfg_q.h      <= {16'd0, cfg_img_height};
      win_channels <= cfg_in_channels;
      // Padded width is formed in 17 bits; a bad width is rejected in LOAD anyway.
      win_width    <= 16'({1'b0, cfg_img_width} + 17'd2);
      cfg_err      <= 1'b0;
    end else if (state == LOAD) begin
      cfg_q.d <= cfg_q.c >> CH_SHIFT;
      if (bad) cfg_err <= 1'b1;
    end
  end

  // Output register: one beat per fire, zero on the border, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_pixel <= '0;
    end else begin
      win_valid <= fire;
      if (fire) win_pixel <= pad ? '0 : s_data;
    end
  end

`ifdef CONV_PAD_FEED_PERF_EN
  logic stall;
  assign stall = (state == STREAM) && (!win_ready || (!pad && !s_valid));

  // Saturating stall and pad-beat counters, cleared on each accepted start.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      perf_stall <= 32'd0;
      perf_pad   <= 32'd0;
    end else begin
      if (stall && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
      if (fire && pad && (perf_pad != '1)) perf_pad <= perf_pad + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_pad_feeder.sv
// Directed bench for conv_pad_feeder: an expected-frame scoreboard is filled
// at each start and drained as win_valid beats appear.
module tb_conv_pad_feeder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cfg_in_channels;
  logic [15:0] cfg_img_width;
  logic [15:0] cfg_img_height;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        win_ready;
  logic        win_valid;
  logic [63:0] win_pixel;
  logic [15:0] win_channels;
  logic [15:0] win_width;

  conv_pad_feeder dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_in_channels (cfg_in_channels),
    .cfg_img_width   (cfg_img_width),
    .cfg_img_height  (cfg_img_height),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .win_ready       (win_ready),
    .win_valid       (win_valid),
    .win_pixel       (win_pixel),
    .win_channels    (win_channels),
    .win_width       (win_width)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  bit          pad_q[$];
  int          total = 0;
  int          n_out = 0;
  int          src_idx = 0;
  int          since_start = 100;
  int          done_cnt = 0;
  bit          active = 0;
  bit          err_mode = 0;
  bit          rst_req = 1;
  bit          start_req = 0;
  bit          start_ign = 0;
  bit          ready_mode = 0;
  bit          valid_mode = 0;
  bit          toggle = 1;
  logic        prev_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] src_val(input int i);
    logic [31:0] u;
    u = i;
    return {32'hC0DE_0000 + u, ~u};
  endfunction

  // Build the expected padded frame and request a start.
  task automatic start_frame(input int c, input int w, input int h);
    int d;
    int k;
    d = c / 8;
    k = 0;
    exp_q.delete();
    pad_q.delete();
    for (int r = 0; r < h + 2; r++)
      for (int cc = 0; cc < w + 2; cc++)
        for (int b = 0; b < d; b++) begin
          bit p;
          p = (r == 0) || (r == h + 1) || (cc == 0) || (cc == w + 1);
          pad_q.push_back(p);
          exp_q.push_back(p ? 64'h0 : src_val(k));
          if (!p) k++;
        end
    total = (h + 2) * (w + 2) * d;
    n_out = 0;
    src_idx = 0;
    done_cnt = 0;
    active = 1;
    err_mode = 0;
    start_req = 1;
    cfg_in_channels = 16'(c);
    cfg_img_width = 16'(w);
    cfg_img_height = 16'(h);
  endtask

  // One clock: check registered outputs, drive this cycle's inputs, check s_ready.
  task automatic step();
    logic        exp_done;
    logic        exp_rdy;
    logic [63:0] exp_pix;
    bit          pad_now;
    @(negedge clk);
    since_start++;
    exp_done = 1'b0;
    chk("valid_without_prior_ready", win_valid & ~prev_ready, 64'd0);
    if (win_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_win_valid", win_valid, 64'd0);
      end else begin
        exp_pix = exp_q.pop_front();
        chk($sformatf("win_pixel[%0d]", n_out), win_pixel, exp_pix);
        n_out++;
        if (active && n_out == total) begin
          exp_done = 1'b1;
          active = 0;
        end
      end
    end
    if (err_mode && since_start == 2) begin
      exp_done = 1'b1;
      err_mode = 0;
    end
    if (done === 1'b1) done_cnt++;
    chk("done", done, exp_done);
    rst = rst_req;
    start = start_req | start_ign;
    if (start_req) since_start = 0;
    start_req = 0;
    start_ign = 0;
    win_ready = ready_mode ? toggle : 1'b1;
    toggle = !toggle;
    s_valid = valid_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    s_data = src_val(src_idx);
    prev_ready = win_ready;
    #1;
    pad_now = (n_out < pad_q.size()) ? pad_q[n_out] : 1'b1;
    exp_rdy = active && (since_start >= 2) && (n_out < total) && !pad_now && win_ready;
    chk("s_ready", s_ready, exp_rdy);
    if (s_valid && s_ready) src_idx++;
  endtask

  task automatic run_frame(input string tag);
    for (int i = 0; i < 2000 && (active || err_mode); i++) step();
    chk({tag, "_beats"}, n_out, total);
  endtask

  task automatic err_case(input int c, input int w, input int h);
    exp_q.delete();
    pad_q.delete();
    total = 0;
    n_out = 0;
    done_cnt = 0;
    active = 0;
    err_mode = 1;
    start_req = 1;
    cfg_in_channels = 16'(c);
    cfg_img_width = 16'(w);
    cfg_img_height = 16'(h);
    step();
    step();
    chk("err_busy_load", busy, 1);
    step();
    step();
    step();
    chk($sformatf("err_cfg_err_c%0d_w%0d_h%0d", c, w, h), cfg_err, 1);
    chk("err_done_cnt", done_cnt, 1);
    chk("err_busy_after", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_in_channels = 16'd0;
    cfg_img_width = 16'd0;
    cfg_img_height = 16'd0;
    s_valid = 1'b0;
    s_data = 64'd0;
    win_ready = 1'b0;

    // Reset state
    rst_req = 1;
    step();
    step();
    rst_req = 0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_pixel", win_pixel, 0);
    chk("rst_win_channels", win_channels, 0);
    chk("rst_win_width", win_width, 0);

    // Ex.1: C=8 W=2 H=2, full throughput
    start_frame(8, 2, 2);
    step();
    step();
    chk("t1_busy_load", busy, 1);
    chk("t1_win_width", win_width, 4);
    run_frame("t1");
    chk("t1_src", src_idx, 4);
    chk("t1_done_cnt", done_cnt, 1);
    step();
    chk("t1_busy_after", busy, 0);

    // Ex.2: C=16 W=3 H=1, two beats per pixel
    start_frame(16, 3, 1);
    step();
    run_frame("t2");
    chk("t2_src", src_idx, 6);
    chk("t2_win_width", win_width, 5);
    chk("t2_win_channels", win_channels, 16);
    chk("t2_done_cnt", done_cnt, 1);
    step();

    // Ex.3: toggling win_ready, random s_valid
    ready_mode = 1;
    valid_mode = 1;
    start_frame(8, 2, 2);
    step();
    run_frame("t3");
    chk("t3_src", src_idx, 4);
    chk("t3_done_cnt", done_cnt, 1);
    ready_mode = 0;
    valid_mode = 0;
    step();

    // Ex.4: bad configs
    err_case(12, 4, 4);
    err_case(1032, 2, 2);
    err_case(8, 0, 3);
    err_case(8, 2, 1025);

    // Next good start clears cfg_err
    start_frame(8, 2, 2);
    step();
    step();
    chk("clr_cfg_err", cfg_err, 0);
    run_frame("t4b");
    step();

    // Ex.5: reset mid-frame after 7 beats
    start_frame(8, 2, 2);
    for (int i = 0; i < 200 && n_out < 7; i++) step();
    chk("t5_reached7", n_out >= 7, 1);
    rst_req = 1;
    step();
    rst_req = 0;
    exp_q.delete();
    pad_q.delete();
    active = 0;
    total = 0;
    done_cnt = 0;
    step();
    chk("t5_win_valid", win_valid, 0);
    chk("t5_win_pixel", win_pixel, 0);
    chk("t5_busy", busy, 0);
    chk("t5_win_width", win_width, 0);
    chk("t5_win_channels", win_channels, 0);
    step();
    step();
    chk("t5_no_done", done_cnt, 0);
    start_frame(8, 2, 2);
    step();
    run_frame("t5b");
    chk("t5b_src", src_idx, 4);
    chk("t5b_done_cnt", done_cnt, 1);
    step();

    // Ex.6: start pulsed mid-frame is ignored
    start_frame(8, 2, 2);
    for (int i = 0; i < 200 && n_out < 5; i++) step();
    start_ign = 1;
    step();
    run_frame("t6");
    chk("t6_src", src_idx, 4);
    chk("t6_done_cnt", done_cnt, 1);
    step();
    step();
    chk("t6_busy_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
